// File: rtl/systolic_requant_wb.sv
// systolic_requant_wb
// Writeback stage behind the NxN systolic array. Each drain beat carries N
// signed 19-bit partial sums. Every lane is requantized to int8 (scale,
// rounding right shift, saturate, optional ReLU). The N bytes are packed
// into one word and written to the output SRAM through an elastic FIFO.
// The array drains unconditionally, so this block never back-pressures it.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_wen_n/in_idx/in_last   drain beat strobe (active low), beat index, final beat
//   psum_in                   N x 19-bit signed lanes, lane i at [19i+18:19i]
//   mult/shamt/relu_en        per-beat requant config (travels with the beat)
//   out_base                  per-beat SRAM base address
//   mem_wdata/mem_waddr       head FIFO entry, zero while the FIFO is empty
//   mem_wen_n/mem_ready       write request (active low) / SRAM accept
//   done                      pulse after the last beat of a drain is written
//   ovf                       sticky: a beat was dropped on a full FIFO
//   sat_cnt                   saturating count of clamped lanes
module systolic_requant_wb #(
    parameter int N      = 8,
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_wen_n,
    input  logic [7:0]          in_idx,
    input  logic                in_last,
    input  logic [N*19-1:0]     psum_in,
    input  logic [7:0]          mult,
    input  logic [4:0]          shamt,
    input  logic                relu_en,
    input  logic [ADDR_W-1:0]   out_base,
    output logic [N*8-1:0]      mem_wdata,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic                mem_wen_n,
    input  logic                mem_ready,
    output logic                done,
    output logic                ovf,
    output logic [15:0]         sat_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(N + 1);
    localparam int EW = N*8 + ADDR_W + 1;

    // Round half up, then arithmetic shift; 29 bits hold prod + rnd.
    function automatic logic signed [28:0] round_shift(input logic signed [27:0] p,
                                                       input logic [4:0] sh);
        logic signed [28:0] rnd;
        logic signed [28:0] sum;
        rnd = (sh == 5'd0) ? 29'sd0 : (29'sd1 <<< (sh - 5'd1));
        sum = 29'(p) + rnd;
        return sum >>> sh;
    endfunction

    // Clamp to int8; with ReLU, negatives go to zero.
    function automatic logic [7:0] sat8(input logic signed [28:0] v, input logic relu);
        if (v > 29'sd127)       return 8'h7F;
        if (relu && v < 29'sd0) return 8'h00;
        if (v < -29'sd128)      return 8'h80;
        return v[7:0];
    endfunction

    // A ReLU clamp of a value still inside int8 range is not a saturation.
    function automatic logic is_sat(input logic signed [28:0] v);
        return (v > 29'sd127) || (v < -29'sd128);
    endfunction

    // ---------------- S1: scale ----------------
    logic                    vld_p1_d, vld_p1_q;
    logic signed [27:0]      prod_p1_d [N];
    logic signed [27:0]      prod_p1_q [N];
    logic [7:0]              idx_p1_d, idx_p1_q;
    logic                    last_p1_d, last_p1_q;
    logic [4:0]              shamt_p1_d, shamt_p1_q;
    logic                    relu_p1_d, relu_p1_q;
    logic [ADDR_W-1:0]       base_p1_d, base_p1_q;

    always_comb begin
        vld_p1_d   = !in_wen_n;
        idx_p1_d   = in_idx;
        last_p1_d  = in_last;
        shamt_p1_d = shamt;
        relu_p1_d  = relu_en;
        base_p1_d  = out_base;
        for (int i = 0; i < N; i++) begin
            prod_p1_d[i] = 28'($signed(psum_in[19*i +: 19])) * 28'($signed({1'b0, mult}));
        end
    end

    // ---------------- S2: round, shift, saturate, address ----------------
    logic                    vld_p2_d, vld_p2_q;
    logic signed [28:0]      v_p2 [N];
    logic [N*8-1:0]          wdata_p2_d, wdata_p2_q;
    logic [ADDR_W-1:0]       waddr_p2_d, waddr_p2_q;
    logic                    last_p2_d, last_p2_q;
    logic [SW-1:0]           nsat_p2;
    logic [16:0]             sat_sum;
    logic [15:0]             sat_cnt_d, sat_cnt_q;

    always_comb begin
        vld_p2_d   = vld_p1_q;
        last_p2_d  = last_p1_q;
        waddr_p2_d = base_p1_q + ADDR_W'(idx_p1_q);
        wdata_p2_d = '0;
        nsat_p2    = '0;
        for (int i = 0; i < N; i++) begin
            v_p2[i] = round_shift(prod_p1_q[i], shamt_p1_q);
            wdata_p2_d[8*i +: 8] = sat8(v_p2[i], relu_p1_q);
            nsat_p2 = nsat_p2 + SW'(is_sat(v_p2[i]));
        end
        sat_sum   = {1'b0, sat_cnt_q} + (vld_p1_q ? 17'(nsat_p2) : 17'd0);
        sat_cnt_d = sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end

    // ---------------- FIFO and SRAM handshake ----------------
    logic [EW-1:0]  fifo_mem_q [DEPTH];
    logic [EW-1:0]  fifo_wr_d;
    logic [EW-1:0]  head;
    logic [AW-1:0]  wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [AW:0]    count_d, count_q;
    logic           empty, full, push, pop, drop;
    logic           done_d, done_q, ovf_d, ovf_q;

    always_comb begin
        fifo_wr_d = {wdata_p2_q, waddr_p2_q, last_p2_q};
        head      = fifo_mem_q[rd_ptr_q];
        empty     = (count_q == '0);
        full      = (count_q == (AW+1)'(DEPTH));
        pop       = !empty && mem_ready;
        // A full FIFO still accepts a push when the head leaves the same cycle.
        push      = vld_p2_q && (!full || pop);
        drop      = vld_p2_q && full && !pop;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (!push && pop) count_d = count_q - (AW+1)'(1);
        done_d    = pop && head[0];
        ovf_d     = ovf_q || drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        prod_p1_q  <= prod_p1_d;
        idx_p1_q   <= idx_p1_d;
        last_p1_q  <= last_p1_d;
        shamt_p1_q <= shamt_p1_d;
        relu_p1_q  <= relu_p1_d;
        base_p1_q  <= base_p1_d;
        wdata_p2_q <= wdata_p2_d;
        waddr_p2_q <= waddr_p2_d;
        last_p2_q  <= last_p2_d;
        if (push && !rst) fifo_mem_q[wr_ptr_q] <= fifo_wr_d;
    end

    // Storage is not reset, so outputs are gated to zero while empty.
    assign mem_wen_n = empty;
    assign mem_wdata = empty ? '0 : head[EW-1 -: N*8];
    assign mem_waddr = empty ? '0 : head[ADDR_W:1];
    assign done      = done_q;
    assign ovf       = ovf_q;
    assign sat_cnt   = sat_cnt_q;
endmodule
